// File: rtl/io_pkg.sv
// rtl/io_pkg.sv - register offsets of the button block, shared with software headers
package io_pkg;

    typedef logic [1:0] reg_off_t;

    localparam reg_off_t REG_STATE  = 2'd0;
    localparam reg_off_t REG_EDGE   = 2'd1;
    localparam reg_off_t REG_IRQ_EN = 2'd2;
    localparam reg_off_t REG_RSVD   = 2'd3;

    function automatic reg_off_t reg_offset(input logic [31:2] addr);
        return addr[3:2];
    endfunction

endpackage

// File: rtl/button_mmap_if.sv
// rtl/button_mmap_if.sv - word-addressed register bus of the button block
interface button_mmap_if;
    logic        re;
    logic [31:0] rd;
    logic        we;
    logic [31:0] wd;
    logic [31:2] addr;

    modport master (output re, we, wd, addr, input rd);
    modport slave  (input re, we, wd, addr, output rd);
endinterface

// File: rtl/debouncer.sv
// rtl/debouncer.sv - one-bit synchronizer plus stable-count debouncer with a rise pulse
module debouncer #(
    parameter int DEBOUNCE_CYCLES = 50000
) (
    input  logic clk,
    input  logic reset,
    input  logic btn,
    output logic state,
    output logic rise
);

    localparam int            CW   = $clog2(DEBOUNCE_CYCLES);
    localparam logic [CW-1:0] LAST = CW'(DEBOUNCE_CYCLES - 1);

    logic          sync1;
    logic          sync2;
    logic [CW-1:0] cnt;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            sync1 <= 1'b0;
            sync2 <= 1'b0;
            cnt   <= '0;
            state <= 1'b0;
        end else begin
            sync1 <= btn;
            sync2 <= sync1;
            if (sync2 == state) begin
                cnt <= '0;
            end else if (cnt == LAST) begin
                state <= sync2;
                cnt   <= '0;
            end else begin
                cnt <= cnt + 1'b1;
            end
        end
    end

    // High in the cycle whose closing edge accepts a press, so EDGE sets together with STATE.
    assign rise = sync2 && !state && (cnt == LAST);

endmodule

// File: rtl/register.sv
// rtl/register.sv - plain enable-loaded register with a configurable reset value
module register #(
    parameter int               WIDTH       = 32,
    parameter logic [WIDTH-1:0] RESET_VALUE = '0
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             en,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] q
);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            q <= RESET_VALUE;
        end else if (en) begin
            q <= d;
        end
    end

endmodule

// File: rtl/button_mmap.sv
// rtl/button_mmap.sv - debounced button inputs with sticky press flags and a level interrupt
module button_mmap
    import io_pkg::*;
#(
    parameter int WIDTH           = 8,
    parameter int DEBOUNCE_CYCLES = 50000
) (
    input  logic               clk,
    input  logic               reset,
    input  logic [WIDTH-1:0]   btn,
    output logic               irq,
    button_mmap_if.slave       bus
);

    logic [WIDTH-1:0] state;
    logic [WIDTH-1:0] rise;
    logic [WIDTH-1:0] edge_q;
    logic [WIDTH-1:0] edge_clr;
    logic [WIDTH-1:0] irq_en;
    reg_off_t         off;
    logic             we_irq_en;
    logic             unused_bits;

    for (genvar i = 0; i < WIDTH; i++) begin : g_db
        debouncer #(
            .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
        ) u_db (
            .clk  (clk),
            .reset(reset),
            .btn  (btn[i]),
            .state(state[i]),
            .rise (rise[i])
        );
    end

    assign off       = reg_offset(bus.addr);
    assign we_irq_en = bus.we && (off == REG_IRQ_EN);
    assign edge_clr  = (bus.we && (off == REG_EDGE)) ? bus.wd[WIDTH-1:0] : '0;

    // Set is OR-ed after the clear so a press landing on a W1C write survives.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            edge_q <= '0;
        end else begin
            edge_q <= (edge_q & ~edge_clr) | rise;
        end
    end

    register #(
        .WIDTH      (WIDTH),
        .RESET_VALUE({WIDTH{1'b0}})
    ) u_irq_en (
        .clk  (clk),
        .reset(reset),
        .en   (we_irq_en),
        .d    (bus.wd[WIDTH-1:0]),
        .q    (irq_en)
    );

    assign irq = |(edge_q & irq_en);

    always_comb begin
        bus.rd = '0;
        case (off)
            REG_STATE:  bus.rd[WIDTH-1:0] = state;
            REG_EDGE:   bus.rd[WIDTH-1:0] = edge_q;
            REG_IRQ_EN: bus.rd[WIDTH-1:0] = irq_en;
            default:    bus.rd = '0;
        endcase
    end

    // Reads are side-effect free and chip select is upstream, so these inputs carry no state.
    assign unused_bits = ^{bus.re, bus.wd, bus.addr};

endmodule

// File: tb/tb_button_mmap.sv
// tb/tb_button_mmap.sv - self-checking bench for button_mmap
module tb_button_mmap;

    localparam int W  = 8;
    localparam int DC = 4;

    logic         clk;
    logic         reset;
    logic [W-1:0] btn;
    logic         irq;

    button_mmap_if bus ();

    button_mmap #(
        .WIDTH          (W),
        .DEBOUNCE_CYCLES(DC)
    ) dut (
        .clk  (clk),
        .reset(reset),
        .btn  (btn),
        .irq  (irq),
        .bus  (bus)
    );

    initial clk = 1'b0;
    always #10 clk = ~clk;

    int n_pass  = 0;
    int n_total = 0;

    // Reference model: a level is accepted once the synchronized input has shown the
    // same differing value for DC consecutive samples.
    logic [W-1:0] hist [0:DC+1];
    logic [W-1:0] m_state;
    logic [W-1:0] m_edge;
    logic [W-1:0] m_en;

    typedef struct {
        logic        we;
        logic [1:0]  off;
        logic [31:0] wd;
        logic [1:0]  rd_off;
        logic [31:0] exp_rd;
    } vec_t;

    vec_t vecs [7];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    endtask

    task automatic model_reset();
        for (int i = 0; i <= DC + 1; i++) hist[i] = '0;
        m_state = '0;
        m_edge  = '0;
        m_en    = '0;
    endtask

    task automatic model_edge(input logic w, input logic [1:0] off, input logic [31:0] d,
                              input logic [W-1:0] b);
        logic [W-1:0] rise;
        logic [W-1:0] nstate;
        logic [W-1:0] clr;
        for (int i = DC + 1; i > 0; i--) hist[i] = hist[i-1];
        hist[0] = b;
        rise   = '0;
        nstate = m_state;
        for (int k = 0; k < W; k++) begin
            int ones = 0;
            for (int j = 2; j <= DC + 1; j++) ones += int'(hist[j][k]);
            if (ones == DC && !m_state[k]) begin
                nstate[k] = 1'b1;
                rise[k]   = 1'b1;
            end else if (ones == 0 && m_state[k]) begin
                nstate[k] = 1'b0;
            end
        end
        clr = (w && off == 2'd1) ? d[W-1:0] : '0;
        m_edge = (m_edge & ~clr) | rise;
        if (w && off == 2'd2) m_en = d[W-1:0];
        m_state = nstate;
    endtask

    task automatic rd_reg(input logic [1:0] o, output logic [31:0] v);
        bus.addr = {28'h0, o};
        #1;
        v = bus.rd;
    endtask

    task automatic check_model();
        logic [31:0] v;
        rd_reg(2'd0, v); chk("m_state",  v, {24'h0, m_state});
        rd_reg(2'd1, v); chk("m_edge",   v, {24'h0, m_edge});
        rd_reg(2'd2, v); chk("m_irq_en", v, {24'h0, m_en});
        rd_reg(2'd3, v); chk("m_rsvd",   v, 32'h0);
        chk("m_irq", {31'h0, irq}, {31'h0, |(m_edge & m_en)});
    endtask

    task automatic step(input logic w, input logic [1:0] off, input logic [31:0] d,
                        input logic [W-1:0] b);
        btn      = b;
        bus.we   = w;
        bus.addr = {28'h0, off};
        bus.wd   = d;
        @(posedge clk);
        model_edge(w, off, d, b);
        #1;
        bus.we = 1'b0;
        check_model();
    endtask

    initial begin
        logic [31:0] v;
        logic [W-1:0] rb;

        reset    = 1'b0;
        btn      = '0;
        bus.re   = 1'b0;
        bus.we   = 1'b0;
        bus.wd   = '0;
        bus.addr = '0;
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        rd_reg(2'd0, v); chk("rst_state",  v, 32'h0);
        rd_reg(2'd1, v); chk("rst_edge",   v, 32'h0);
        rd_reg(2'd2, v); chk("rst_irq_en", v, 32'h0);
        chk("rst_irq", {31'h0, irq}, 32'h0);
        reset = 1'b1;

        vecs[0] = '{1'b0, 2'd3, 32'h0,         2'd3, 32'h0};
        vecs[1] = '{1'b1, 2'd0, 32'h0000_00AA, 2'd0, 32'h0};
        vecs[2] = '{1'b1, 2'd2, 32'hFFFF_FF5A, 2'd2, 32'h0000_005A};
        vecs[3] = '{1'b1, 2'd3, 32'hFFFF_FFFF, 2'd3, 32'h0};
        vecs[4] = '{1'b1, 2'd3, 32'hFFFF_FFFF, 2'd2, 32'h0000_005A};
        vecs[5] = '{1'b1, 2'd1, 32'hFFFF_FFFF, 2'd1, 32'h0};
        vecs[6] = '{1'b1, 2'd2, 32'h0,         2'd2, 32'h0};
        for (int i = 0; i < 7; i++) begin
            step(vecs[i].we, vecs[i].off, vecs[i].wd, 8'h00);
            rd_reg(vecs[i].rd_off, v);
            chk($sformatf("map%0d", i), v, vecs[i].exp_rd);
        end

        // glitch on btn[1] three cycles wide
        for (int i = 0; i < 9; i++) begin
            step(1'b0, 2'd0, 32'h0, (i < 3) ? 8'h02 : 8'h00);
            rd_reg(2'd0, v); chk("glitch_state", v, 32'h0);
            rd_reg(2'd1, v); chk("glitch_edge",  v, 32'h0);
        end

        // press: accepted on exactly the sixth edge
        for (int i = 1; i <= 10; i++) begin
            step(1'b0, 2'd0, 32'h0, 8'h01);
            rd_reg(2'd0, v); chk($sformatf("press_state%0d", i), v, (i >= 6) ? 32'h1 : 32'h0);
        end
        rd_reg(2'd1, v); chk("press_edge", v, 32'h1);

        // W1C and set-beats-clear
        repeat (6) step(1'b0, 2'd0, 32'h0, 8'h03);
        rd_reg(2'd1, v); chk("w1c_pre", v, 32'h3);
        step(1'b1, 2'd1, 32'h1, 8'h03);
        rd_reg(2'd1, v); chk("w1c_clr", v, 32'h2);
        repeat (5) step(1'b0, 2'd0, 32'h0, 8'h07);
        step(1'b1, 2'd1, 32'h4, 8'h07);
        rd_reg(2'd0, v); chk("race_state", v, 32'h7);
        rd_reg(2'd1, v); chk("race_edge",  v, 32'h6);
        step(1'b1, 2'd1, 32'h4, 8'h07);
        rd_reg(2'd1, v); chk("race_clr", v, 32'h2);

        // releases do not set EDGE
        step(1'b1, 2'd1, 32'hFF, 8'h07);
        repeat (6) step(1'b0, 2'd0, 32'h0, 8'h00);
        rd_reg(2'd0, v); chk("rel_state", v, 32'h0);
        rd_reg(2'd1, v); chk("rel_edge",  v, 32'h0);

        // interrupt masking
        step(1'b1, 2'd2, 32'h2, 8'h00);
        repeat (6) step(1'b0, 2'd0, 32'h0, 8'h01);
        chk("irq_masked", {31'h0, irq}, 32'h0);
        repeat (6) step(1'b0, 2'd0, 32'h0, 8'h03);
        chk("irq_set", {31'h0, irq}, 32'h1);
        step(1'b1, 2'd1, 32'h2, 8'h03);
        chk("irq_clr", {31'h0, irq}, 32'h0);
        step(1'b1, 2'd2, 32'hFF, 8'h03);
        chk("irq_en_all", {31'h0, irq}, 32'h1);

        // reset mid-debounce
        repeat (3) step(1'b0, 2'd0, 32'h0, 8'hFF);
        reset = 1'b0;
        #1;
        rd_reg(2'd0, v); chk("arst_state",  v, 32'h0);
        rd_reg(2'd1, v); chk("arst_edge",   v, 32'h0);
        rd_reg(2'd2, v); chk("arst_irq_en", v, 32'h0);
        chk("arst_irq", {31'h0, irq}, 32'h0);
        @(posedge clk);
        #1;
        reset = 1'b1;
        model_reset();
        for (int i = 1; i <= 6; i++) begin
            step(1'b0, 2'd0, 32'h0, 8'hFF);
            rd_reg(2'd0, v); chk($sformatf("post_rst_state%0d", i), v, (i == 6) ? 32'hFF : 32'h0);
        end
        rd_reg(2'd1, v); chk("post_rst_edge", v, 32'hFF);

        // random traffic against the model
        rb = 8'hFF;
        for (int n = 0; n < 600; n++) begin
            for (int b = 0; b < W; b++) if ($urandom_range(4) == 0) rb[b] = ~rb[b];
            step(($urandom_range(3) == 0), 2'($urandom_range(3)), $urandom, rb);
        end

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule

// File: doc/button_mmap.md
BUTTON_MMAP -- requirements
Module: button_mmap

Interface
REQ-001 The block SHALL have parameter WIDTH, default 8, giving the number of button inputs (1..32).
REQ-002 The block SHALL have parameter DEBOUNCE_CYCLES, default 50000, giving the number of stable cycles required before a level is accepted (>=2).
REQ-003 The block SHALL have port clk, input, 1 bit: the single clock; all state changes on its rising edge.
REQ-004 The block SHALL have port reset, input, 1 bit: asynchronous, active-low reset.
REQ-005 The block SHALL have port btn, input, WIDTH bits: raw asynchronous button levels, 1 = pressed.
REQ-006 The block SHALL have port irq, output, 1 bit: level interrupt request.
REQ-007 The block SHALL have port re, input, 1 bit: read enable; it has no side effects.
REQ-008 The block SHALL have port rd, output, 32 bits: read data, combinational from addr.
REQ-009 The block SHALL have port we, input, 1 bit: write enable, sampled at the clk edge.
REQ-010 The block SHALL have port wd, input, 32 bits: write data.
REQ-011 The block SHALL have port addr, input, 30 bits [31:2]: word address; only addr[3:2] is decoded, and chip select is done upstream.

Function
REQ-012 Each btn bit SHALL pass through a 2-flop synchronizer before any other use.
REQ-013 Each bit SHALL have an independent debounce counter, sized $clog2(DEBOUNCE_CYCLES) bits, that behaves as follows:
- cleared when the synchronized value equals the debounced state;
- incremented when the synchronized value differs from the debounced state;
- at count DEBOUNCE_CYCLES-1, while still differing, the debounced state takes the synchronized value and the counter clears.
REQ-014 Latency from a stable btn change to the STATE change SHALL be exactly 2 + DEBOUNCE_CYCLES clk edges; a glitch shorter than DEBOUNCE_CYCLES synchronized cycles SHALL produce no change.
REQ-015 On each debounced 0->1 transition, the matching EDGE bit SHALL be set (sticky).
REQ-016 The register map on addr[3:2] SHALL be:
- 0 STATE: RO, the debounced levels;
- 1 EDGE: W1C;
- 2 IRQ_EN: RW, reset 0;
- 3: reads 0, writes ignored.
REQ-017 rd SHALL be zero-extended above WIDTH bits, and writes to bits above WIDTH SHALL be ignored.
REQ-018 Writes to STATE SHALL be ignored.
REQ-019 A write to EDGE SHALL clear the bits where wd is 1; if a set and a clear hit the same bit in the same cycle, the set SHALL win (the bit stays 1).
REQ-020 irq SHALL equal |(EDGE & IRQ_EN), registered-free: combinational from the flops.
REQ-021 A debounced 1->0 transition (release) SHALL update STATE only and SHALL NOT set EDGE.

Reset
REQ-022 While reset is 0, the following SHALL all be 0 immediately and asynchronously: synchronizer flops, counters, STATE, EDGE, IRQ_EN and irq.
REQ-023 After reset deassertion, a button held pressed through reset SHALL be treated as a new press: STATE becomes 1 and EDGE is set after 2 + DEBOUNCE_CYCLES edges.
REQ-024 Reset asserted mid-debounce SHALL discard the partial count.

Structure
REQ-025 The register offsets (STATE=0, EDGE=1, IRQ_EN=2) SHALL be localparams in a shared package, io_pkg, reused by software headers.
REQ-026 One sub-module, debouncer, SHALL be used:
- it is 1 bit wide, holds the synchronizer, counter and state, and outputs the state plus a 1-cycle rise pulse;
- it is instantiated WIDTH times via generate.
REQ-027 IRQ_EN SHALL use the existing register module with RESET_VALUE 0.

Verification (bench uses WIDTH=8, DEBOUNCE_CYCLES=4)
REQ-028 Press: btn=8'h01 held for 10 cycles -> STATE reads 8'h01 exactly 6 edges after the change, and EDGE reads 8'h01.
REQ-029 Glitch: btn[1] high for 3 cycles then low -> STATE and EDGE stay 8'h00 throughout.
REQ-030 W1C race: EDGE=8'h03 and a write of 8'h01 to EDGE -> EDGE=8'h02. A write of 8'h04 on the same edge that btn[2] rises -> EDGE bit 2 stays 1.
REQ-031 IRQ: IRQ_EN=8'h02 and btn[0] pressed -> irq stays 0. Then btn[1] pressed -> irq=1. Then a write of 8'h02 to EDGE -> irq=0 on the next cycle.
REQ-032 Reset: reset pulsed low mid-debounce with btn=8'hFF -> all outputs 0 at once. After release, STATE becomes 8'hFF and EDGE becomes 8'hFF after 6 edges.
REQ-033 Map: a read of offset 3 -> 0. A write of 8'hAA to STATE -> STATE unchanged. A write of 32'hFFFF_FF5A to IRQ_EN -> it reads 32'h0000_005A.
